seq_debug_cmd_issuer: RTL and testbench
=======================================

Name: seq_debug_cmd_issuer

Overview:
- Avalon-MM master that drives the sequencer core debug command mailbox from a host-side command request (JTAG bridge or Nios-side debug agent).
- Per command: arms CMD_STATUS, writes the parameter words, writes REQ_CMD, then polls CMD_STATUS until completion or timeout, and returns the final status word.
- Sits directly upstream of the sequencer debug mailbox on the sequencer Avalon bus.

Parameters:
- AVL_ADDR_WIDTH, 20, byte-address width of avm_address.
- CMD_BASE, 20'h153C8, mailbox base. REQ_CMD = CMD_BASE+0, CMD_STATUS = CMD_BASE+4, CMD_PARAMS = CMD_BASE+8.
- MAX_PARAMS, 4, parameter words per command (1..8).
- STATUS_BUSY, 32'h1, value written to CMD_STATUS before issue. Polling continues while readdata equals this value.
- POLL_GAP, 16, idle cycles between consecutive status reads (>=1).
- TIMEOUT_POLLS, 1024, maximum status reads before the command is abandoned.

Ports:
- avl_clk, in, 1: clock.
- avl_reset_n, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: issuer idle and accepting a command.
- cmd_code, in, 32: value written to REQ_CMD.
- cmd_nparams, in, $clog2(MAX_PARAMS+1): number of parameter words to write.
- cmd_params, in, 32*MAX_PARAMS: parameter words, word i in bits [32i+31:32i].
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_status, out, 32: last CMD_STATUS value read.
- rsp_timeout, out, 1: the command was abandoned on timeout.
- avm_address, out, AVL_ADDR_WIDTH: byte address.
- avm_write, out, 1: write request.
- avm_read, out, 1: read request.
- avm_writedata, out, 32: write data.
- avm_readdata, in, 32: read data.
- avm_readdatavalid, in, 1: read data strobe.
- avm_waitrequest, in, 1: slave stall.

Behaviour:
- Reset values: cmd_ready=1; rsp_valid=0; rsp_status=0; rsp_timeout=0; avm_write=0; avm_read=0; avm_address=0; avm_writedata=0; FSM in IDLE.
- Handshake: command accepted on the cycle cmd_valid && cmd_ready. Code, nparams (clamped to MAX_PARAMS) and params are latched; cmd_ready drops the next cycle. Inputs are ignored until return to IDLE.
- FSM states and transitions:
  - IDLE: on accept, go to WR_STAT.
  - WR_STAT: write STATUS_BUSY to CMD_STATUS. Go to WR_PARAM if nparams>0, else WR_REQ.
  - WR_PARAM: write word i to CMD_PARAMS+4*i. i increments per accepted write. After word nparams-1, go to WR_REQ.
  - WR_REQ: write cmd_code to REQ_CMD, then go to GAP.
  - GAP: count POLL_GAP cycles, then go to RD.
  - RD: assert avm_read at CMD_STATUS. Once accepted, go to RD_WAIT and increment poll_cnt.
  - RD_WAIT: on readdatavalid, capture rsp_status. If readdata!=STATUS_BUSY, go to DONE. Else if poll_cnt==TIMEOUT_POLLS, go to DONE with timeout=1. Else go to GAP.
  - DONE: pulse rsp_valid for one cycle, then return to IDLE with cmd_ready=1 on the following cycle.
- Avalon rules:
  - Address, data and strobe are held stable while avm_waitrequest=1.
  - A transfer is accepted on a cycle with strobe=1 and waitrequest=0.
  - avm_read and avm_write are never asserted together.
  - At most one read is outstanding.
- Latency, no waitrequest, nparams=N, first read returns non-busy: rsp_valid occurs 1+1+N+1+POLL_GAP+1+read latency+1 cycles after accept.
- Timeout: exactly TIMEOUT_POLLS reads are issued.
- rsp_timeout is updated in DONE and held until the next DONE.
- cmd_valid asserted during an active command has no effect.
- Reset mid-transfer: all strobes drop asynchronously and the FSM returns to IDLE. No partial command state is retained.
- poll_cnt width is $clog2(TIMEOUT_POLLS+1). poll_cnt clears on accept.

Optional Feature:
- Macro: SEQ_DEBUG_CMD_STATS_EN.
- Defined: adds outputs stat_cmd_count (16), stat_timeout_count (16) and stat_last_polls ($clog2(TIMEOUT_POLLS+1)).
  - stat_cmd_count increments on each DONE and saturates at 16'hFFFF.
  - stat_timeout_count increments on timeout DONE and saturates at 16'hFFFF.
  - stat_last_polls loads poll_cnt at DONE.
  - All three reset to 0.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Basic command: cmd_code=32'h2A, nparams=2, params {32'h11,32'h22}, no waitrequest, first read 32'h0. Required writes in order: 0x153CC←1, 0x153D0←0x11, 0x153D4←0x22, 0x153C8←0x2A. Then one read at 0x153CC; rsp_valid with rsp_status=0 and rsp_timeout=0.
- Polling: readdata returns 1,1,1 then 32'h4. Required: 4 reads spaced ≥POLL_GAP idle cycles; rsp_status=4, rsp_timeout=0.
- Timeout: TIMEOUT_POLLS=8, readdata always 1. Required: exactly 8 reads, rsp_timeout=1, rsp_status=1.
- Backpressure: waitrequest high 3 cycles on every transfer, nparams=0. Required: address, data and strobe stable while stalled; no duplicate writes; rsp_valid still produced.
- Clamp and ignore: nparams=7 with MAX_PARAMS=4 gives exactly 4 param writes. cmd_valid pulsed mid-command is ignored (one REQ_CMD write only).
- Reset mid-command: avl_reset_n low during WR_PARAM. Required: strobes 0 immediately; after release cmd_ready=1; a new command runs cleanly from WR_STAT.

Source files
------------

// File: rtl/seq_debug_cmd_issuer.sv
`default_nettype none
//==============================================================================
// Module  : seq_debug_cmd_issuer
// Purpose : Avalon-MM master that posts one debug command to the sequencer
//           mailbox (arm status, write params, write request, poll status).
// Option  : define SEQ_DEBUG_CMD_STATS_EN to add command/timeout statistics.
// Rev     : 1.0
//==============================================================================
module seq_debug_cmd_issuer #(
  parameter int                        AVL_ADDR_WIDTH = 20,
  parameter logic [AVL_ADDR_WIDTH-1:0] CMD_BASE       = 20'h153C8,
  parameter int                        MAX_PARAMS     = 4,
  parameter logic [31:0]               STATUS_BUSY    = 32'h1,
  parameter int                        POLL_GAP       = 16,
  parameter int                        TIMEOUT_POLLS  = 1024,
  localparam int                       NP_W           = $clog2(MAX_PARAMS + 1),
  localparam int                       PC_W           = $clog2(TIMEOUT_POLLS + 1)
) (
  input  logic                       avl_clk,
  input  logic                       avl_reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_code,
  input  logic [NP_W-1:0]            cmd_nparams,
  input  logic [32*MAX_PARAMS-1:0]   cmd_params,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_status,
  output logic                       rsp_timeout,
  output logic [AVL_ADDR_WIDTH-1:0]  avm_address,
  output logic                       avm_write,
  output logic                       avm_read,
  output logic [31:0]                avm_writedata,
  input  logic [31:0]                avm_readdata,
  input  logic                       avm_readdatavalid,
  input  logic                       avm_waitrequest
`ifdef SEQ_DEBUG_CMD_STATS_EN
  ,
  output logic [15:0]                stat_cmd_count,
  output logic [15:0]                stat_timeout_count,
  output logic [PC_W-1:0]            stat_last_polls
`endif
);

  localparam int IDX_W = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [AVL_ADDR_WIDTH-1:0] c_REQ_ADDR   = CMD_BASE;
  localparam logic [AVL_ADDR_WIDTH-1:0] c_STAT_ADDR  = CMD_BASE + AVL_ADDR_WIDTH'(4);
  localparam logic [AVL_ADDR_WIDTH-1:0] c_PARAM_ADDR = CMD_BASE + AVL_ADDR_WIDTH'(8);
  localparam logic [GAP_W-1:0]          c_GAP_LAST   = GAP_W'(POLL_GAP - 1);
  localparam logic [NP_W-1:0]           c_NP_MAX     = NP_W'(MAX_PARAMS);
  localparam logic [PC_W-1:0]           c_POLL_MAX   = PC_W'(TIMEOUT_POLLS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_STAT  = 3'd1,
    S_WR_PARAM = 3'd2,
    S_WR_REQ   = 3'd3,
    S_GAP      = 3'd4,
    S_RD       = 3'd5,
    S_RD_WAIT  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [31:0]                 r_code;
  logic [32*MAX_PARAMS-1:0]    r_params;
  logic [NP_W-1:0]             r_remain;
  logic [IDX_W-1:0]            r_idx;
  logic [GAP_W-1:0]            r_gap_cnt;
  logic [PC_W-1:0]             r_poll_cnt;
  logic                        r_to_pending;
  logic                        r_rsp_valid;
  logic [31:0]                 r_rsp_status;
  logic                        r_rsp_timeout;

  logic                        w_accept;
  logic                        w_xfer_ok;
  logic                        w_busy_rd;
  logic [NP_W-1:0]             w_np_clamped;
  logic [AVL_ADDR_WIDTH-1:0]   w_param_addr;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_xfer_ok    = !avm_waitrequest;
  assign w_busy_rd    = (avm_readdata == STATUS_BUSY);
  assign w_np_clamped = (cmd_nparams > c_NP_MAX) ? c_NP_MAX : cmd_nparams;
  assign w_param_addr = c_PARAM_ADDR + AVL_ADDR_WIDTH'({r_idx, 2'b00});

  assign cmd_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_rsp_status;
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    w_state_nxt   = r_state;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WR_STAT;
        end
      end
      S_WR_STAT: begin
        avm_write     = 1'b1;
        avm_address   = c_STAT_ADDR;
        avm_writedata = STATUS_BUSY;
        if (w_xfer_ok) begin
          w_state_nxt = (r_remain != '0) ? S_WR_PARAM : S_WR_REQ;
        end
      end
      S_WR_PARAM: begin
        avm_write     = 1'b1;
        avm_address   = w_param_addr;
        avm_writedata = r_params[31:0];
        if (w_xfer_ok && (r_remain == NP_W'(1))) begin
          w_state_nxt = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        avm_write     = 1'b1;
        avm_address   = c_REQ_ADDR;
        avm_writedata = r_code;
        if (w_xfer_ok) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        avm_read    = 1'b1;
        avm_address = c_STAT_ADDR;
        if (w_xfer_ok) begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (!w_busy_rd || (r_poll_cnt == c_POLL_MAX)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_GAP;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_code        <= '0;
      r_params      <= '0;
      r_remain      <= '0;
      r_idx         <= '0;
      r_gap_cnt     <= '0;
      r_poll_cnt    <= '0;
      r_to_pending  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= (r_state == S_DONE);
      r_gap_cnt   <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_code       <= cmd_code;
            r_params     <= cmd_params;
            r_remain     <= w_np_clamped;
            r_idx        <= '0;
            r_poll_cnt   <= '0;
            r_to_pending <= 1'b0;
          end
        end
        S_WR_PARAM: begin
          // Params are shifted down so the next word is always in the low slot.
          if (w_xfer_ok) begin
            r_params <= r_params >> 32;
            r_remain <= r_remain - 1'b1;
            r_idx    <= r_idx + 1'b1;
          end
        end
        S_RD: begin
          if (w_xfer_ok) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            r_rsp_status <= avm_readdata;
            r_to_pending <= w_busy_rd && (r_poll_cnt == c_POLL_MAX);
          end
        end
        S_DONE: begin
          r_rsp_timeout <= r_to_pending;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SEQ_DEBUG_CMD_STATS_EN
  logic [15:0]     r_stat_cmd;
  logic [15:0]     r_stat_to;
  logic [PC_W-1:0] r_stat_polls;

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_stat_cmd   <= '0;
      r_stat_to    <= '0;
      r_stat_polls <= '0;
    end else if (r_state == S_DONE) begin
      r_stat_polls <= r_poll_cnt;
      if (r_stat_cmd != 16'hFFFF) begin
        r_stat_cmd <= r_stat_cmd + 16'd1;
      end
      if (r_to_pending && (r_stat_to != 16'hFFFF)) begin
        r_stat_to <= r_stat_to + 16'd1;
      end
    end
  end

  assign stat_cmd_count     = r_stat_cmd;
  assign stat_timeout_count = r_stat_to;
  assign stat_last_polls    = r_stat_polls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_debug_cmd_issuer.sv
`default_nettype none
//==============================================================================
// Module  : tb_seq_debug_cmd_issuer
// Purpose : Directed + randomized bench with an Avalon slave model and a
//           transaction-level expectation of writes, reads, status and latency.
// Rev     : 1.0
//==============================================================================
module tb_seq_debug_cmd_issuer;

  localparam int              AW     = 20;
  localparam int              MAXP   = 4;
  localparam int              PG     = 16;
  localparam int              TO     = 8;
  localparam int              RD_LAT = 1;
  localparam int              NPW    = $clog2(MAXP + 1);
  localparam int              PCW    = $clog2(TO + 1);
  localparam logic [AW-1:0]   BASE   = 20'h153C8;
  localparam logic [31:0]     BUSY   = 32'h1;

  logic                  avl_clk;
  logic                  avl_reset_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [31:0]           cmd_code;
  logic [NPW-1:0]        cmd_nparams;
  logic [32*MAXP-1:0]    cmd_params;
  logic                  rsp_valid;
  logic [31:0]           rsp_status;
  logic                  rsp_timeout;
  logic [AW-1:0]         avm_address;
  logic                  avm_write;
  logic                  avm_read;
  logic [31:0]           avm_writedata;
  logic [31:0]           avm_readdata;
  logic                  avm_readdatavalid;
  logic                  avm_waitrequest;
`ifdef SEQ_DEBUG_CMD_STATS_EN
  logic [15:0]           stat_cmd_count;
  logic [15:0]           stat_timeout_count;
  logic [PCW-1:0]        stat_last_polls;
`endif

  seq_debug_cmd_issuer #(
    .AVL_ADDR_WIDTH (AW),
    .CMD_BASE       (BASE),
    .MAX_PARAMS     (MAXP),
    .STATUS_BUSY    (BUSY),
    .POLL_GAP       (PG),
    .TIMEOUT_POLLS  (TO)
  ) u_dut (
    .avl_clk           (avl_clk),
    .avl_reset_n       (avl_reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_nparams       (cmd_nparams),
    .cmd_params        (cmd_params),
    .rsp_valid         (rsp_valid),
    .rsp_status        (rsp_status),
    .rsp_timeout       (rsp_timeout),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
`ifdef SEQ_DEBUG_CMD_STATS_EN
    ,
    .stat_cmd_count     (stat_cmd_count),
    .stat_timeout_count (stat_timeout_count),
    .stat_last_polls    (stat_last_polls)
`endif
  );

  initial avl_clk = 1'b0;
  always #5 avl_clk = ~avl_clk;

  int cyc = 0;
  always @(posedge avl_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model state and transaction logs
  logic [31:0]   rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            rc_q[$];
  int            stall_cfg = 0;
  int            stall_cnt = 0;
  bit            pend = 0;
  bit            prev_stalled = 0;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_data;
  logic          p_wr, p_rd;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge avl_clk);
      if (!avl_reset_n) begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        pend = 0; prev_stalled = 0; stall_cnt = 0;
      end else begin
        avm_readdatavalid = 1'b0;
        if (pend) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
          pend = 0;
        end
        if (prev_stalled) begin
          check("stall_addr", avm_address, p_addr);
          check("stall_data", avm_writedata, p_data);
          check("stall_wr", avm_write, p_wr);
          check("stall_rd", avm_read, p_rd);
        end
        if (avm_write || avm_read) begin
          check("rd_wr_excl", avm_write & avm_read, 1'b0);
          if (stall_cnt < stall_cfg) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
            prev_stalled = 1;
            p_addr = avm_address; p_data = avm_writedata;
            p_wr = avm_write; p_rd = avm_read;
          end else begin
            avm_waitrequest = 1'b0;
            stall_cnt = 0;
            prev_stalled = 0;
            if (avm_write) begin
              wa_q.push_back(avm_address);
              wd_q.push_back(avm_writedata);
            end else begin
              pend = 1;
              rc_q.push_back(cyc);
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          prev_stalled = 0;
        end
      end
    end
  end

  logic [31:0] tp [MAXP];

  task automatic drive_cmd(input logic [31:0] code, input int np);
    cmd_valid   = 1'b1;
    cmd_code    = code;
    cmd_nparams = NPW'(np);
    for (int i = 0; i < MAXP; i++) cmd_params[32*i +: 32] = tp[i];
  endtask

  // Expectations come from the mailbox protocol: the write list, the read
  // response sequence, and the cycle budget of each phase.
  task automatic do_cmd(input logic [31:0] code, input int np, input int nbusy,
                        input logic [31:0] fin, input int stall, input bit poke,
                        input string tag);
    int nw, nreads, exp_lat, acc, lat;
    logic [31:0]   exp_st;
    logic          exp_to;
    logic [AW-1:0] ea[$];
    logic [31:0]   ed[$];
    nw = (np > MAXP) ? MAXP : np;
    ea.push_back(BASE + 20'd4); ed.push_back(BUSY);
    for (int i = 0; i < nw; i++) begin
      ea.push_back(BASE + 20'd8 + AW'(4 * i)); ed.push_back(tp[i]);
    end
    ea.push_back(BASE); ed.push_back(code);
    rd_q.delete(); wa_q.delete(); wd_q.delete(); rc_q.delete();
    if (nbusy >= TO) begin
      for (int i = 0; i < TO; i++) rd_q.push_back(BUSY);
      nreads = TO; exp_st = BUSY; exp_to = 1'b1;
    end else begin
      for (int i = 0; i < nbusy; i++) rd_q.push_back(BUSY);
      rd_q.push_back(fin);
      nreads = nbusy + 1; exp_st = fin; exp_to = 1'b0;
    end
    exp_lat = 1 + 1 + nw + 1 + PG + 1 + RD_LAT + 1 + (nreads - 1) * (PG + 1 + RD_LAT);
    stall_cfg = stall;

    @(negedge avl_clk);
    drive_cmd(code, np);
    check($sformatf("%s ready_idle", tag), cmd_ready, 1'b1);
    acc = cyc;
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    check($sformatf("%s ready_drop", tag), cmd_ready, 1'b0);
    if (poke) begin
      repeat (3) @(negedge avl_clk);
      drive_cmd(~code, 1);
      repeat (3) @(negedge avl_clk);
      cmd_valid = 1'b0;
    end
    for (int k = 0; k < 4000 && !rsp_valid; k++) @(negedge avl_clk);
    check($sformatf("%s rsp_seen", tag), rsp_valid, 1'b1);
    lat = cyc - acc;
    if (stall == 0) check($sformatf("%s latency", tag), lat, exp_lat);
    check($sformatf("%s status", tag), rsp_status, exp_st);
    check($sformatf("%s timeout", tag), rsp_timeout, exp_to);
    check($sformatf("%s n_writes", tag), wa_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s wr%0d_addr", tag, i), wa_q[i], ea[i]);
      check($sformatf("%s wr%0d_data", tag, i), wd_q[i], ed[i]);
    end
    check($sformatf("%s n_reads", tag), rc_q.size(), nreads);
    for (int i = 1; i < rc_q.size(); i++)
      check($sformatf("%s rd_gap%0d", tag, i), (rc_q[i] - rc_q[i-1] - 1) >= PG, 1'b1);
    @(negedge avl_clk);
    check($sformatf("%s rsp_pulse", tag), rsp_valid, 1'b0);
    check($sformatf("%s ready_back", tag), cmd_ready, 1'b1);
    check($sformatf("%s status_hold", tag), rsp_status, exp_st);
    check($sformatf("%s timeout_hold", tag), rsp_timeout, exp_to);
  endtask

  initial begin
    logic [31:0] fin;
    avl_reset_n = 1'b0;
    cmd_valid   = 1'b0;
    cmd_code    = '0;
    cmd_nparams = '0;
    cmd_params  = '0;
    for (int i = 0; i < MAXP; i++) tp[i] = '0;
    #1;
    check("rst cmd_ready", cmd_ready, 1'b1);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst rsp_status", rsp_status, 32'h0);
    check("rst rsp_timeout", rsp_timeout, 1'b0);
    check("rst avm_write", avm_write, 1'b0);
    check("rst avm_read", avm_read, 1'b0);
    check("rst avm_address", avm_address, 20'h0);
    check("rst avm_writedata", avm_writedata, 32'h0);
    repeat (3) @(negedge avl_clk);
    avl_reset_n = 1'b1;
    repeat (2) @(negedge avl_clk);

    tp[0] = 32'h11; tp[1] = 32'h22; tp[2] = 32'h0; tp[3] = 32'h0;
    do_cmd(32'h2A, 2, 0, 32'h0, 0, 0, "basic");

    tp[0] = $urandom;
    do_cmd($urandom, 1, 3, 32'h4, 0, 0, "poll");

    do_cmd($urandom, 0, TO, 32'h0, 0, 0, "tmo");

    do_cmd($urandom, 0, 1, 32'h5, 3, 0, "bp");

    for (int i = 0; i < MAXP; i++) tp[i] = $urandom;
    do_cmd($urandom, 7, 0, 32'h77, 0, 1, "clamp");

    // Reset while parameter words are being written
    for (int i = 0; i < MAXP; i++) tp[i] = $urandom;
    rd_q.delete(); wa_q.delete(); wd_q.delete(); rc_q.delete();
    stall_cfg = 0;
    @(negedge avl_clk);
    drive_cmd(32'hDEAD, 4);
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && wa_q.size() < 2; k++) @(negedge avl_clk);
    @(negedge avl_clk);
    #2;
    check("mid pre_write", avm_write, 1'b1);
    avl_reset_n = 1'b0;
    #1;
    check("mid avm_write", avm_write, 1'b0);
    check("mid avm_read", avm_read, 1'b0);
    check("mid avm_address", avm_address, 20'h0);
    check("mid cmd_ready", cmd_ready, 1'b1);
    check("mid rsp_status", rsp_status, 32'h0);
    repeat (2) @(negedge avl_clk);
    #2 avl_reset_n = 1'b1;
    @(negedge avl_clk);
    check("post cmd_ready", cmd_ready, 1'b1);
    check("post rsp_valid", rsp_valid, 1'b0);
    for (int i = 0; i < MAXP; i++) tp[i] = $urandom;
    do_cmd($urandom, 3, 0, 32'h9, 0, 0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < MAXP; i++) tp[i] = $urandom;
      fin = $urandom;
      if (fin == BUSY) fin = 32'h2;
      do_cmd($urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             fin, int'($urandom_range(0, 2)), 0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
